// File: rtl/instruction_fetch.sv
// Single-issue instruction fetch stage: an 8-bit PC with a one-entry output slot toward decode,
// branch redirect, and a terminal HALT state entered on fetching the halt opcode.
module instruction_fetch #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] instruction_address,
    input  logic [7:0] instruction_data,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    output logic [7:0] fetched_instruction,
    output logic [7:0] fetched_pc,
    output logic       fetch_valid,
    input  logic       decode_ready,
    output logic       halted
);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] pc_r, pc_s;
    logic [7:0] instr_r, instr_s;
    logic [7:0] fpc_r, fpc_s;
    logic       valid_r, valid_s;
    logic       halted_r, halted_s;
    logic       slot_free_s;

    assign instruction_address = pc_r;
    assign fetched_instruction = instr_r;
    assign fetched_pc          = fpc_r;
    assign fetch_valid         = valid_r;
    assign halted              = halted_r;

    // Next-state logic: branch wins over capture and stall; HALT only drains the slot.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        instr_s     = instr_r;
        fpc_s       = fpc_r;
        valid_s     = valid_r;
        halted_s    = halted_r;
        slot_free_s = (!valid_r) || decode_ready;
        case (state_r)
            RUN: begin
                if (branch_taken) begin
                    pc_s    = branch_target;
                    valid_s = 1'b0;
                end else if (slot_free_s) begin
                    instr_s = instruction_data;
                    fpc_s   = pc_r;
                    valid_s = 1'b1;
                    pc_s    = pc_r + 8'd1;
                    if (instruction_data == HALT_OPCODE) begin
                        state_s  = HALT;
                        halted_s = 1'b1;
                    end else begin
                        state_s  = RUN;
                        halted_s = 1'b0;
                    end
                end else begin
                    valid_s = valid_r;
                end
            end
            HALT: begin
                halted_s = 1'b1;
                if (valid_r && decode_ready) begin
                    valid_s = 1'b0;
                end else begin
                    valid_s = valid_r;
                end
            end
            default: begin
                // Unreachable encoding: park safely with the slot empty.
                state_s  = HALT;
                halted_s = 1'b1;
                valid_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= RUN;
            pc_r     <= RESET_PC;
            instr_r  <= 8'h00;
            fpc_r    <= 8'h00;
            valid_r  <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            instr_r  <= instr_s;
            fpc_r    <= fpc_s;
            valid_r  <= valid_s;
            halted_r <= halted_s;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: combinational memory model plus a queue of
// expected (pc, instruction) pairs compared as the fetch stage presents them.
module tb_instruction_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] instruction_address;
    logic [7:0] instruction_data;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [7:0] fetched_instruction;
    logic [7:0] fetched_pc;
    logic       fetch_valid;
    logic       decode_ready;
    logic       halted;

    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];
    logic [15:0] exp_item;
    int checks = 0;
    int errors = 0;

    instruction_fetch #(.RESET_PC(8'h00), .HALT_OPCODE(8'hFF)) dut (
        .clk                 (clk),
        .reset               (reset),
        .instruction_address (instruction_address),
        .instruction_data    (instruction_data),
        .branch_taken        (branch_taken),
        .branch_target       (branch_target),
        .fetched_instruction (fetched_instruction),
        .fetched_pc          (fetched_pc),
        .fetch_valid         (fetch_valid),
        .decode_ready        (decode_ready),
        .halted              (halted)
    );

    always #5 clk = ~clk;
    assign instruction_data = mem[instruction_address];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        branch_taken = 1'b0;
        decode_ready = 1'b0;
        exp_q.delete();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        branch_taken = 1'b0;
        branch_target = 8'h00;
        decode_ready = 1'b0;
        #1;
        checks++;
        if ({fetch_valid, halted, fetched_pc, fetched_instruction, instruction_address} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b halted=%b fpc=%h instr=%h addr=%h, want all zero",
                     fetch_valid, halted, fetched_pc, fetched_instruction, instruction_address);
        end
        #3;
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back({8'(i), mem[i]});
        decode_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_item = exp_q.pop_front();
            checks++;
            if ({fetch_valid, fetched_pc, fetched_instruction} !== {1'b1, exp_item}) begin
                errors++;
                $display("FAIL seq_capture%0d: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                         i, fetch_valid, fetched_pc, fetched_instruction, exp_item[15:8], exp_item[7:0]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        exp_q.push_back({8'h00, 8'h10});
        exp_q.push_back({8'h01, 8'h11});
        decode_ready = 1'b1;
        tick();
        exp_item = exp_q.pop_front();
        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({fetch_valid, fetched_pc, fetched_instruction, instruction_address} !== {1'b1, exp_item, 8'h01}) begin
                errors++;
                $display("FAIL stall_hold%0d: got v=%b pc=%h ins=%h addr=%h, want v=1 pc=00 ins=10 addr=01",
                         i, fetch_valid, fetched_pc, fetched_instruction, instruction_address);
            end
        end
        decode_ready = 1'b1;
        tick();
        exp_item = exp_q.pop_front();
        checks++;
        if ({fetch_valid, fetched_pc, fetched_instruction} !== {1'b1, exp_item}) begin
            errors++;
            $display("FAIL stall_release: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                     fetch_valid, fetched_pc, fetched_instruction, exp_item[15:8], exp_item[7:0]);
        end
    endtask

    task automatic test_branch();
        do_reset();
        decode_ready = 1'b1;
        tick();
        decode_ready = 1'b0;
        tick();
        branch_taken = 1'b1;
        branch_target = 8'h40;
        exp_q.push_back({8'h40, mem[8'h40]});
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({fetch_valid, instruction_address} !== {1'b0, 8'h40}) begin
            errors++;
            $display("FAIL branch_redirect: got v=%b addr=%h, want v=0 addr=40", fetch_valid, instruction_address);
        end
        tick();
        exp_item = exp_q.pop_front();
        checks++;
        if ({fetch_valid, fetched_pc, fetched_instruction} !== {1'b1, exp_item}) begin
            errors++;
            $display("FAIL branch_fetch: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                     fetch_valid, fetched_pc, fetched_instruction, exp_item[15:8], exp_item[7:0]);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] a;
        do_reset();
        decode_ready = 1'b1;
        branch_taken = 1'b1;
        branch_target = 8'hFE;
        tick();
        branch_taken = 1'b0;
        a = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({a, mem[a]});
            a = a + 8'd1;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_item = exp_q.pop_front();
            checks++;
            if ({fetch_valid, fetched_pc, fetched_instruction} !== {1'b1, exp_item}) begin
                errors++;
                $display("FAIL wrap_fetch%0d: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                         i, fetch_valid, fetched_pc, fetched_instruction, exp_item[15:8], exp_item[7:0]);
            end
        end
        checks++;
        if (instruction_address !== 8'h01) begin
            errors++;
            $display("FAIL wrap_pc: got addr=%h, want 01", instruction_address);
        end
    endtask

    task automatic test_halt();
        do_reset();
        mem[5] = 8'hFF;
        for (int i = 0; i < 6; i++) exp_q.push_back({8'(i), mem[i]});
        decode_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_item = exp_q.pop_front();
            checks++;
            if ({fetch_valid, fetched_pc, fetched_instruction} !== {1'b1, exp_item}) begin
                errors++;
                $display("FAIL halt_stream%0d: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                         i, fetch_valid, fetched_pc, fetched_instruction, exp_item[15:8], exp_item[7:0]);
            end
        end
        checks++;
        if ({halted, instruction_address} !== {1'b1, 8'h06}) begin
            errors++;
            $display("FAIL halt_enter: got halted=%b addr=%h, want halted=1 addr=06", halted, instruction_address);
        end
        tick();
        branch_taken = 1'b1;
        branch_target = 8'h30;
        checks++;
        if ({fetch_valid, halted, instruction_address} !== {1'b0, 1'b1, 8'h06}) begin
            errors++;
            $display("FAIL halt_drain: got v=%b halted=%b addr=%h, want v=0 halted=1 addr=06",
                     fetch_valid, halted, instruction_address);
        end
        tick();
        tick();
        branch_taken = 1'b0;
        checks++;
        if ({fetch_valid, halted, instruction_address} !== {1'b0, 1'b1, 8'h06}) begin
            errors++;
            $display("FAIL halt_ignore_branch: got v=%b halted=%b addr=%h, want v=0 halted=1 addr=06",
                     fetch_valid, halted, instruction_address);
        end
        mem[5] = 8'h05;
    endtask

    task automatic test_async_reset();
        do_reset();
        decode_ready = 1'b1;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({fetch_valid, halted, fetched_pc, fetched_instruction, instruction_address} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b halted=%b fpc=%h ins=%h addr=%h, want all zero",
                     fetch_valid, halted, fetched_pc, fetched_instruction, instruction_address);
        end
        #1;
        reset = 1'b0;
        exp_q.push_back({8'h00, mem[0]});
        tick();
        exp_item = exp_q.pop_front();
        checks++;
        if ({fetch_valid, fetched_pc, fetched_instruction} !== {1'b1, exp_item}) begin
            errors++;
            $display("FAIL async_refetch: got v=%b pc=%h ins=%h, want v=1 pc=%h ins=%h",
                     fetch_valid, fetched_pc, fetched_instruction, exp_item[15:8], exp_item[7:0]);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset();
        for (int i = 0; i < 40; i++) exp_q.push_back({8'(i), mem[i]});
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 300) begin
            decode_ready = 1'($urandom_range(0, 1));
            if (fetch_valid && decode_ready) begin
                exp_item = exp_q.pop_front();
                checks++;
                if ({fetched_pc, fetched_instruction} !== exp_item) begin
                    errors++;
                    $display("FAIL b2b_handshake: got pc=%h ins=%h, want pc=%h ins=%h",
                             fetched_pc, fetched_instruction, exp_item[15:8], exp_item[7:0]);
                end
            end
            tick();
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d items left, want 0", exp_q.size());
        end
        decode_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {1'b0, 7'(i)};
        mem[0] = 8'h10;
        mem[1] = 8'h11;
        mem[2] = 8'h12;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_wrap();
        test_halt();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00, the PC value loaded on reset.
REQ-002 SHALL have parameter HALT_OPCODE, default 8'hFF, the instruction byte that stops fetching.
REQ-003 SHALL have one clock, clk (input, 1), with all state updating on its rising edge.
REQ-004 SHALL have reset (input, 1), asynchronous and active-high.
REQ-005 SHALL have instruction_address (output, 8), the current PC driven to the instruction memory address port.
REQ-006 SHALL have instruction_data (input, 8), the combinational same-cycle memory read of instruction_address.
REQ-007 SHALL have branch_taken (input, 1), a redirect request from downstream.
REQ-008 SHALL have branch_target (input, 8), the redirect PC, valid while branch_taken=1.
REQ-009 SHALL have fetched_instruction (output, 8), the registered instruction byte presented to decode.
REQ-010 SHALL have fetched_pc (output, 8), the address from which fetched_instruction was read.
REQ-011 SHALL have fetch_valid (output, 1), meaning fetched_instruction and fetched_pc hold a valid instruction.
REQ-012 SHALL have decode_ready (input, 1), meaning decode accepts the output slot this cycle.
REQ-013 SHALL have halted (output, 1), asserted in state HALT.

Function
REQ-014 SHALL drive instruction_address combinationally from the internal PC register.
REQ-015 SHALL implement two states, RUN and HALT.
REQ-016 SHALL define the output slot as free when fetch_valid=0 or decode_ready=1, and handshake completes when fetch_valid=1 and decode_ready=1.
REQ-017 In RUN with slot free and branch_taken=0, SHALL capture instruction_data into fetched_instruction and PC into fetched_pc, set fetch_valid=1, and set PC=PC+1.
REQ-018 SHALL give one-cycle latency from PC presentation to fetched_instruction.
REQ-019 SHALL compute PC increments modulo 256, so 8'hFF wraps to 8'h00 with no flag.
REQ-020 In RUN with slot not free (fetch_valid=1, decode_ready=0), SHALL hold PC, fetched_instruction, fetched_pc and fetch_valid unchanged.
REQ-021 In RUN with branch_taken=1, SHALL set PC=branch_target and fetch_valid=0 in the same edge, regardless of decode_ready or stall.
REQ-022 SHALL give branch_taken priority over capture and stall, with no capture that cycle.
REQ-023 On capture of a byte equal to HALT_OPCODE, SHALL present it normally with fetch_valid=1, leave PC at the halt address +1, and move to HALT.
REQ-024 In HALT, SHALL hold PC and perform no capture.
REQ-025 In HALT, SHALL keep fetch_valid=1 until the halt instruction handshakes, then clear it to 0 and keep it 0.
REQ-026 In HALT, SHALL ignore branch_taken; only reset exits HALT.
REQ-027 SHALL assert halted=1 from the first cycle in HALT.
REQ-028 SHALL be free of combinational paths from decode_ready or branch_taken to any output.

Reset
REQ-029 On reset=1, SHALL asynchronously set PC=RESET_PC, fetched_instruction=8'h00, fetched_pc=8'h00, fetch_valid=0, halted=0 and state=RUN.
REQ-030 SHALL discard any in-flight instruction when reset is asserted mid-operation.
REQ-031 SHALL fetch from RESET_PC on the first rising edge after reset deasserts.

Verification
REQ-032 Memory holds 8'h10,8'h11,8'h12 at 0..2, decode_ready=1 after reset -> fetched_instruction 10,11,12 on edges 1..3, fetched_pc 0,1,2, fetch_valid=1 from edge 1.
REQ-033 decode_ready=0 for 3 cycles after the first capture -> fetched_instruction=8'h10, fetched_pc=0, instruction_address=1 held throughout; 8'h11 appears one edge after decode_ready returns to 1.
REQ-034 branch_taken=1 with branch_target=8'h40 while stalled -> next edge PC=8'h40, fetch_valid=0; the following edge gives fetched_pc=8'h40.
REQ-035 Branch to 8'hFE, memory non-halt at FE,FF,00 -> fetched_pc sequence FE,FF,00 (wrap).
REQ-036 8'hFF at address 5, decode_ready=1 -> fetched_pc=5 with fetch_valid=1 for one cycle, then fetch_valid=0, halted=1, instruction_address=6 stable; branch_taken=1 is ignored.
REQ-037 Assert reset asynchronously between edges mid-stream -> outputs take reset values immediately without a clock edge, and refetch begins at RESET_PC.
